// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register (hold/shr/shl/load) with serialisation counter.
// Define USR_ROTATE_EN to turn the shifts into rotates; the serial inputs are then ignored.
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int CW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_msb,
   input  logic             sin_lsb,
   output logic [WIDTH-1:0] q,
   output logic             sout_lsb,
   output logic             sout_msb,
   output logic [CW-1:0]    shift_cnt,
   output logic             done
);
   logic [WIDTH-1:0] shr, shl;
   logic wrap;
`ifdef USR_ROTATE_EN
   assign shr = {q[0], q[WIDTH-1:1]};
   assign shl = {q[WIDTH-2:0], q[WIDTH-1]};
`else
   assign shr = {sin_msb, q[WIDTH-1:1]};
   assign shl = {q[WIDTH-2:0], sin_lsb};
`endif
   assign wrap = shift_cnt == CW'(WIDTH - 1);
   assign sout_lsb = q[0];
   assign sout_msb = q[WIDTH-1];
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VAL;
         shift_cnt <= '0;
         done <= 1'b0;
      end else if (!en || mode == 2'b00) begin
         done <= 1'b0;
      end else if (mode == 2'b11) begin
         q <= d;
         shift_cnt <= '0;
         done <= 1'b0;
      end else begin
         q <= mode[0] ? shr : shl;
         shift_cnt <= wrap ? '0 : shift_cnt + 1'b1;
         done <= wrap;
      end
   end
endmodule
